// File: rtl/draw_pkg.sv
// Shared definitions for the drawing-engine scheduler.
//   X_W / Y_W / C_W    : VGA plot port field widths (x, y, color)
//   DEFAULT_FRAME_DIV  : clk cycles per frame tick, 60 Hz from a 50 MHz clock
//   sched_state_t      : scheduler FSM states
package draw_pkg;

   localparam int X_W = 8;
   localparam int Y_W = 7;
   localparam int C_W = 3;

   localparam int DEFAULT_FRAME_DIV = 833333;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_DONE,
      RELEASE,
      NEXT,
      FRAME_END
   } sched_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame tick generator.
// Counts 0..FRAME_DIV-1 and pulses tick for one cycle at the terminal count.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset (count returns to 0)
//   tick   out one-cycle pulse every FRAME_DIV cycles
module frame_tick_gen
   import draw_pkg::*;
#(
   parameter int FRAME_DIV = DEFAULT_FRAME_DIV
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_DIV - 1);

   logic [CNT_W-1:0] count;

   assign tick = (count == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/draw_frame_scheduler.sv
// Per-frame sequencer for drawing engines sharing one VGA plot port.
// On each frame tick (while enabled) every client is run in order 0..N-1
// through a begin_draw/done 4-phase handshake; only the active client's
// pixel stream reaches the VGA port.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | no frame in progress, waiting for tick && enable
// START     | raise begin_draw for the current client, clear phase timer
// WAIT_DONE | begin_draw high, waiting for done (or phase timeout)
// RELEASE   | begin_draw low, waiting for done to drop (or phase timeout)
// NEXT      | advance to next client or finish the frame
// FRAME_END | drop frame_busy, count the completed frame
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   enable              allow new frames to start
//   begin_draw / done   per-client handshake
//   client_x/y/color    packed per-client pixel fields (client i in slice i)
//   client_drawEn       per-client plot strobes
//   x, y, color, drawEn registered VGA plot port
//   frame_busy          high from frame start until frame completion
//   frame_count         completed frames, wraps
//   overrun             sticky: tick arrived while a frame was in progress
//   timeout_err         sticky per-client handshake timeout
module draw_frame_scheduler
   import draw_pkg::*;
#(
   parameter int NUM_CLIENTS = 4,
   parameter int FRAME_DIV   = DEFAULT_FRAME_DIV,
   parameter int TIMEOUT     = 65535
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   output logic [NUM_CLIENTS-1:0]       begin_draw,
   input  logic [NUM_CLIENTS-1:0]       done,
   input  logic [X_W*NUM_CLIENTS-1:0]   client_x,
   input  logic [Y_W*NUM_CLIENTS-1:0]   client_y,
   input  logic [C_W*NUM_CLIENTS-1:0]   client_color,
   input  logic [NUM_CLIENTS-1:0]       client_drawEn,
   output logic [X_W-1:0]               x,
   output logic [Y_W-1:0]               y,
   output logic [C_W-1:0]               color,
   output logic                         drawEn,
   output logic                         frame_busy,
   output logic [7:0]                   frame_count,
   output logic                         overrun,
   output logic [NUM_CLIENTS-1:0]       timeout_err
);

   localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);
   localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

   sched_state_t     state;
   logic [IDX_W-1:0] index;
   logic [TMR_W-1:0] timer;
   logic             tick;
   logic             timer_max;

   logic [X_W-1:0] x_sel     [NUM_CLIENTS];
   logic [Y_W-1:0] y_sel     [NUM_CLIENTS];
   logic [C_W-1:0] color_sel [NUM_CLIENTS];

   frame_tick_gen #(
      .FRAME_DIV (FRAME_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
      assign x_sel[i]     = client_x[i*X_W +: X_W];
      assign y_sel[i]     = client_y[i*Y_W +: Y_W];
      assign color_sel[i] = client_color[i*C_W +: C_W];
   end

   assign timer_max = (timer == TMR_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         index       <= '0;
         timer       <= '0;
         begin_draw  <= '0;
         frame_busy  <= 1'b0;
         frame_count <= '0;
         overrun     <= 1'b0;
         timeout_err <= '0;
      end else begin
         // A tick during a frame is only flagged; the frame is never restarted.
         if (tick && (state != IDLE)) begin
            overrun <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (tick && enable) begin
                  state      <= START;
                  index      <= '0;
                  frame_busy <= 1'b1;
               end
            end

            START: begin
               begin_draw <= NUM_CLIENTS'(1) << index;
               timer      <= '0;
               state      <= WAIT_DONE;
            end

            WAIT_DONE: begin
               if (done[index]) begin
                  begin_draw <= '0;
                  timer      <= '0;
                  state      <= RELEASE;
               end else if (timer_max) begin
                  timeout_err[index] <= 1'b1;
                  begin_draw         <= '0;
                  timer              <= '0;
                  state              <= RELEASE;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end

            RELEASE: begin
               if (!done[index]) begin
                  state <= NEXT;
               end else if (timer_max) begin
                  timeout_err[index] <= 1'b1;
                  state              <= NEXT;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end

            NEXT: begin
               if (index == LAST_IDX) begin
                  state <= FRAME_END;
               end else begin
                  index <= index + IDX_W'(1);
                  state <= START;
               end
            end

            FRAME_END: begin
               frame_busy  <= 1'b0;
               frame_count <= frame_count + 8'd1;
               state       <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

   // Pixel fields follow the selected client every cycle; the plot strobe is
   // gated so that only a client holding begin_draw can write the screen.
   always_ff @(posedge clk) begin
      if (reset) begin
         x      <= '0;
         y      <= '0;
         color  <= '0;
         drawEn <= 1'b0;
      end else begin
         x      <= x_sel[index];
         y      <= y_sel[index];
         color  <= color_sel[index];
         drawEn <= (state == WAIT_DONE) && client_drawEn[index];
      end
   end

endmodule

// File: tb/tb_draw_frame_scheduler.sv
// Self-checking bench for draw_frame_scheduler (4 clients, FRAME_DIV=100,
// TIMEOUT=20). Client done behaviour is modelled in the bench; a scenario
// table covers handshake timing, timeouts and overrun, followed by hand
// sequences for the pixel mux, enable drop and mid-frame reset.
module tb_draw_frame_scheduler;

   localparam int NC   = 4;
   localparam int FDIV = 100;
   localparam int TMO  = 20;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            enable = 1'b0;
   logic [NC-1:0]   begin_draw;
   logic [NC-1:0]   done = '0;
   logic [8*NC-1:0] client_x = '0;
   logic [7*NC-1:0] client_y = '0;
   logic [3*NC-1:0] client_color = '0;
   logic [NC-1:0]   client_drawEn = '0;
   logic [7:0]      x;
   logic [6:0]      y;
   logic [2:0]      color;
   logic            drawEn;
   logic            frame_busy;
   logic [7:0]      frame_count;
   logic            overrun;
   logic [NC-1:0]   timeout_err;

   draw_frame_scheduler #(
      .NUM_CLIENTS (NC),
      .FRAME_DIV   (FDIV),
      .TIMEOUT     (TMO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .begin_draw    (begin_draw),
      .done          (done),
      .client_x      (client_x),
      .client_y      (client_y),
      .client_color  (client_color),
      .client_drawEn (client_drawEn),
      .x             (x),
      .y             (y),
      .color         (color),
      .drawEn        (drawEn),
      .frame_busy    (frame_busy),
      .frame_count   (frame_count),
      .overrun       (overrun),
      .timeout_err   (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            rise;
      int            fall;
      logic [NC-1:0] stuck;
      logic [NC-1:0] exp_err;
      logic          exp_ovr;
   } vec_t;

   typedef struct {
      logic       en;
      logic       chk;
      logic [7:0] px;
      logic [6:0] py;
      logic [2:0] pc;
   } pix_t;

   vec_t  vecs[5];
   pix_t  sb_q[$];
   int    order_q[$];

   int    n_vec = 0;
   int    n_miss = 0;
   int    rise_d = 5;
   int    fall_d = 1;
   logic [NC-1:0] stuck = '0;
   int    cb[NC];
   int    cf[NC];
   int    run_cur[NC];
   int    last_len[NC];
   logic [NC-1:0] bd_prev = '0;
   bit    pix_on = 1'b0;
   int    pulses = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One clock: sample at negedge, monitor the handshake, run client model,
   // and (when enabled) drive/score the pixel mux.
   task automatic step();
      pix_t e;
      @(negedge clk);
      check("begin_draw_onehot", 32'($countones(begin_draw) <= 1), 32'(1));
      for (int i = 0; i < NC; i++) begin
         if (begin_draw[i]) begin
            if (!bd_prev[i]) begin
               order_q.push_back(i);
               run_cur[i] = 0;
            end
            run_cur[i]++;
         end else if (bd_prev[i]) begin
            last_len[i] = run_cur[i];
         end
      end
      bd_prev = begin_draw;

      for (int i = 0; i < NC; i++) begin
         if (begin_draw[i]) begin
            cf[i] = 0;
            cb[i]++;
            if (!stuck[i] && cb[i] == rise_d) done[i] = 1'b1;
         end else begin
            cb[i] = 0;
            if (done[i]) begin
               cf[i]++;
               if (cf[i] >= fall_d) done[i] = 1'b0;
            end
         end
      end

      if (pix_on) begin
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("pix_drawEn", 32'(drawEn), 32'(e.en));
            if (e.chk) begin
               check("pix_x", 32'(x), 32'(e.px));
               check("pix_y", 32'(y), 32'(e.py));
               check("pix_color", 32'(color), 32'(e.pc));
            end
            if (drawEn) pulses++;
         end
         client_drawEn = '0;
         if (begin_draw[2]) begin
            client_drawEn[0] = 1'b1;
            if (run_cur[2] >= 2 && run_cur[2] <= 4) client_drawEn[2] = 1'b1;
         end
         e.en = 1'b0;
         e.chk = 1'b0;
         e.px = '0;
         e.py = '0;
         e.pc = '0;
         for (int i = 0; i < NC; i++) begin
            if (begin_draw[i]) begin
               e.en  = client_drawEn[i];
               e.chk = 1'b1;
               e.px  = client_x[i*8 +: 8];
               e.py  = client_y[i*7 +: 7];
               e.pc  = client_color[i*3 +: 3];
            end
         end
         sb_q.push_back(e);
      end
   endtask

   task automatic model_clear();
      done = '0;
      bd_prev = '0;
      for (int i = 0; i < NC; i++) begin
         cb[i] = 0;
         cf[i] = 0;
         run_cur[i] = 0;
         last_len[i] = 0;
      end
      order_q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_clear();
   endtask

   task automatic wait_busy(input logic lvl, input int limit, output int n);
      n = 0;
      while (frame_busy !== lvl && n < limit) begin
         step();
         n++;
      end
      check("wait_frame_busy", 32'(frame_busy), 32'(lvl));
   endtask

   task automatic wait_bd(input int idx, input int limit, output int n);
      n = 0;
      while (begin_draw[idx] !== 1'b1 && n < limit) begin
         step();
         n++;
      end
      check("wait_begin_draw", 32'(begin_draw[idx]), 32'(1));
   endtask

   task automatic check_order(input int first, input int count);
      check("order_len", 32'(order_q.size()), 32'(first + count));
      for (int k = first; k < first + count; k++) begin
         if (k < order_q.size()) check("order", 32'(order_q[k]), 32'(k % NC));
      end
   endtask

   initial begin
      int n1, n2, busy_cnt;
      vecs[0] = '{5,  1,  4'b0000, 4'b0000, 1'b0};
      vecs[1] = '{1,  1,  4'b0000, 4'b0000, 1'b0};
      vecs[2] = '{5,  1,  4'b0010, 4'b0010, 1'b0};
      vecs[3] = '{3,  2,  4'b1001, 4'b1001, 1'b0};
      vecs[4] = '{18, 18, 4'b0000, 4'b0000, 1'b1};

      for (int i = 0; i < NC; i++) begin
         client_x[i*8 +: 8]     = 8'(16 * i + 7);
         client_y[i*7 +: 7]     = 7'(10 * i + 1);
         client_color[i*3 +: 3] = 3'(i + 1);
      end
      client_x[23:16]    = 8'd159;
      client_y[20:14]    = 7'd119;
      client_color[8:6]  = 3'b101;

      // reset state
      step();
      check("rst_begin_draw", 32'(begin_draw), 32'(0));
      check("rst_frame_busy", 32'(frame_busy), 32'(0));
      check("rst_frame_count", 32'(frame_count), 32'(0));
      check("rst_drawEn", 32'(drawEn), 32'(0));
      check("rst_x", 32'(x), 32'(0));

      // scenario table
      for (int v = 0; v < 5; v++) begin
         rise_d = vecs[v].rise;
         fall_d = vecs[v].fall;
         stuck  = vecs[v].stuck;
         enable = 1'b1;
         do_reset();
         wait_busy(1'b1, 300, n1);
         check("start_latency", 32'(n1), 32'(FDIV));
         wait_busy(1'b0, 400, n2);
         check("frame_count", 32'(frame_count), 32'(1));
         check("timeout_err", 32'(timeout_err), 32'(vecs[v].exp_err));
         check("overrun", 32'(overrun), 32'(vecs[v].exp_ovr));
         check_order(0, NC);
         for (int i = 0; i < NC; i++) begin
            check("begin_draw_len", 32'(last_len[i]), 32'(stuck[i] ? TMO + 1 : rise_d));
         end
         if (vecs[v].exp_ovr) begin
            wait_busy(1'b1, 300, n1);
            wait_busy(1'b0, 400, n2);
            check("frame_count_2", 32'(frame_count), 32'(2));
            check_order(NC, NC);
         end else begin
            check("busy_before_tick2", 32'((n1 + n2) < 2 * FDIV), 32'(1));
         end
      end

      // pixel mux: client 2 plots 3 times, client 0 strobes alongside
      rise_d = 8;
      fall_d = 1;
      stuck  = '0;
      enable = 1'b1;
      do_reset();
      sb_q.delete();
      pulses = 0;
      pix_on = 1'b1;
      wait_busy(1'b1, 300, n1);
      wait_busy(1'b0, 400, n2);
      step();
      pix_on = 1'b0;
      client_drawEn = '0;
      sb_q.delete();
      check("pix_pulses", 32'(pulses), 32'(3));

      // enable dropped during client 1
      rise_d = 5;
      fall_d = 1;
      enable = 1'b1;
      do_reset();
      wait_bd(1, 300, n1);
      enable = 1'b0;
      wait_busy(1'b0, 400, n2);
      check("dis_frame_count", 32'(frame_count), 32'(1));
      check_order(0, NC);
      busy_cnt = 0;
      repeat (150) begin
         step();
         if (frame_busy) busy_cnt++;
      end
      check("dis_busy_cycles", 32'(busy_cnt), 32'(0));
      check("dis_frame_count_hold", 32'(frame_count), 32'(1));
      check("dis_no_new_client", 32'(order_q.size()), 32'(NC));

      // reset while client 2 is active, with sticky flags set
      rise_d = 18;
      fall_d = 18;
      stuck  = 4'b1000;
      enable = 1'b1;
      do_reset();
      wait_busy(1'b1, 300, n1);
      wait_busy(1'b0, 400, n2);
      wait_bd(2, 400, n1);
      client_drawEn = 4'b0100;
      repeat (3) step();
      check("pre_begin_draw", 32'(begin_draw), 32'(4'b0100));
      check("pre_drawEn", 32'(drawEn), 32'(1));
      check("pre_x", 32'(x), 32'(159));
      check("pre_overrun", 32'(overrun), 32'(1));
      check("pre_timeout_err", 32'(timeout_err), 32'(4'b1000));
      check("pre_frame_count", 32'(frame_count), 32'(1));
      reset = 1'b1;
      step();
      check("post_begin_draw", 32'(begin_draw), 32'(0));
      check("post_x", 32'(x), 32'(0));
      check("post_y", 32'(y), 32'(0));
      check("post_color", 32'(color), 32'(0));
      check("post_drawEn", 32'(drawEn), 32'(0));
      check("post_frame_count", 32'(frame_count), 32'(0));
      check("post_overrun", 32'(overrun), 32'(0));
      check("post_timeout_err", 32'(timeout_err), 32'(0));
      check("post_frame_busy", 32'(frame_busy), 32'(0));
      reset = 1'b0;
      model_clear();
      client_drawEn = '0;
      n1 = 0;
      while (begin_draw == '0 && n1 < 300) begin
         step();
         n1++;
      end
      check("restart_latency", 32'(n1), 32'(FDIV + 1));
      check("restart_client", 32'(begin_draw), 32'(4'b0001));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
